// File: rtl/bitwise_logic_unit.sv
// Bitwise AND/OR/XOR/NOR unit feeding a DEPTH-entry result FIFO, one-cycle latency.
// Optional head-parity output and per-entry parity storage: BITWISE_LOGIC_UNIT_PARITY_EN.

module bitwise_logic_lane (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (op)
      2'b00: y = a & b;
      2'b01: y = a | b;
      2'b10: y = a ^ b;
      2'b11: y = ~(a | b);
      default: y = 1'b0;
    endcase
  end
endmodule

module bitwise_logic_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [1:0]       ctrl_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             isZero,
  output logic [15:0]      op_count
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    logic             par;
`endif
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [WIDTH-1:0] op_res;
  logic [CW-1:0]    count_q, count_nxt;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             in_ready_q;
  logic [15:0]      op_count_q;
  logic             accept, pop;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bitwise_logic_lane u_lane (
      .a  (data_operandA[i]),
      .b  (data_operandB[i]),
      .op (ctrl_op),
      .y  (op_res[i])
    );
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept = in_valid & in_ready_q;
  assign pop    = (count_q != '0) & out_ready;

  always_comb begin
    count_nxt = count_q;
    case ({accept, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = op_res;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    wr_entry.par  = ^op_res;
`endif
  end

  // in_ready is a register of the next occupancy, so out_ready never reaches it combinationally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      count_q    <= count_nxt;
      in_ready_q <= (count_nxt < CW'(DEPTH));
      if (accept) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (op_count_q != 16'hFFFF) op_count_q <= op_count_q + 16'd1;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset: nothing is visible unless count says the entry is live
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr_q] <= wr_entry;
  end

  assign head      = mem[rd_ptr_q];
  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign result    = out_valid ? head.data : '0;
  assign isZero    = out_valid & (head.data == '0);
  assign op_count  = op_count_q;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
  assign parity    = out_valid & head.par;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit (WIDTH=32, DEPTH=2).
module tb_bitwise_logic_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA, data_operandB;
  logic [1:0]  ctrl_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        isZero;
  logic [15:0] op_count;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
  logic        parity;
`endif

  int checks = 0;
  int errors = 0;

  bitwise_logic_unit #(.WIDTH(32), .DEPTH(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_op       (ctrl_op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .isZero        (isZero),
    .op_count      (op_count)
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    ,
    .parity        (parity)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    in_valid = v; data_operandA = a; data_operandB = b; ctrl_op = op;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 2'b00);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_isZero", isZero, 0);
    chk("rst_op_count", op_count, 0);
    @(negedge clock); reset_n = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    tick();
    chk("in_ready_after_edge", in_ready, 1);

    // Single AND: E & F = E
    out_ready = 1'b1;
    drive(1'b1, 32'h0000000E, 32'h0000000F, 2'b00);
    tick();
    drive(1'b0, '0, '0, 2'b00);
    chk("and_valid", out_valid, 1);
    chk("and_result", result, 32'h0000000E);
    chk("and_isZero", isZero, 0);
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    chk("and_parity", parity, 1);
`endif
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_result", result, 0);

    // All four ops back-to-back
    drive(1'b1, 32'hFFFF0000, 32'h0000FFFF, 2'b00); tick();
    chk("op00_result", result, 32'h00000000);
    chk("op00_isZero", isZero, 1);
    drive(1'b1, 32'hFFFF0000, 32'h0000FFFF, 2'b01); tick();
    chk("op01_result", result, 32'hFFFFFFFF);
    chk("op01_isZero", isZero, 0);
    drive(1'b1, 32'hFFFF0000, 32'h0000FFFF, 2'b10); tick();
    chk("op10_result", result, 32'hFFFFFFFF);
    drive(1'b1, 32'hFFFF0000, 32'h0000FFFF, 2'b11); tick();
    chk("op11_result", result, 32'h00000000);
    chk("op11_valid", out_valid, 1);
    drive(1'b0, '0, '0, 2'b00); tick();
    chk("ops_op_count", op_count, 5);

    // Fill to full with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd0, 2'b01); tick();
    chk("fill1_in_ready", in_ready, 1);
    drive(1'b1, 32'd2, 32'd0, 2'b01); tick();
    chk("full_in_ready", in_ready, 0);
    drive(1'b1, 32'd3, 32'd0, 2'b01); tick();
    chk("full_held_in_ready", in_ready, 0);
    chk("full_op_count", op_count, 7);
    chk("full_head", result, 1);
    out_ready = 1'b1; tick();
    chk("pop_full_result", result, 2);
    chk("pop_full_in_ready", in_ready, 1);
    tick();
    chk("third_result", result, 3);
    chk("third_op_count", op_count, 8);
    drive(1'b0, '0, '0, 2'b00); tick();
    chk("fill_drained", out_valid, 0);

    // Steady stream: XOR against a constant, one result per cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h01010101 * i, 32'h5A5A5A5A, 2'b10); tick();
      chk($sformatf("stream_result_%0d", i), result, (32'h01010101 * i) ^ 32'h5A5A5A5A);
      chk($sformatf("stream_in_ready_%0d", i), in_ready, 1);
    end
    chk("stream_op_count", op_count, 28);
    drive(1'b0, '0, '0, 2'b00); tick();

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'hAA, 32'h0, 2'b01); tick();
    drive(1'b1, 32'hBB, 32'h0, 2'b01); tick();
    drive(1'b0, '0, '0, 2'b00);
    chk("pre_reset_result", result, 32'hAA);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clock); reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_result", result, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Saturation: run op_count up to FFFE, then three more accepts
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 32'h0, 32'h0, 2'b11); tick();
    end
    chk("sat_fffe", op_count, 16'hFFFE);
    drive(1'b1, 32'h0, 32'h0, 2'b11); tick();
    chk("sat_ffff_1", op_count, 16'hFFFF);
    drive(1'b1, 32'h0, 32'h0, 2'b11); tick();
    drive(1'b1, 32'h12345678, 32'h0F0F0F0F, 2'b00); tick();
    chk("sat_ffff_3", op_count, 16'hFFFF);
    chk("sat_result", result, 32'h02040608);
    drive(1'b0, '0, '0, 2'b00); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
